// File: rtl/gmii_frame_arb.sv
// N-input whole-frame arbiter for the Ethernet TX path: serialises complete frames onto
// one GMII-side stream with an enforced interframe gap. Optional macro GMII_FRAME_ARB_PAD_EN.

module gmii_frame_arb #(
    parameter int NUM_INPUTS     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int INTERFRAME_GAP = 12,
    parameter int ARB_MODE       = 0,
    parameter int MIN_FRAME_LEN  = 60,
    localparam int SRC_W         = $clog2(NUM_INPUTS)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] Input_data [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0] Input_valid,
    input  logic [NUM_INPUTS-1:0] Input_last,
    output logic [NUM_INPUTS-1:0] Input_ready,
    output logic [DATA_WIDTH-1:0] Output_data,
    output logic                  Output_valid,
    output logic                  Output_last,
    output logic [SRC_W-1:0]      Output_src,
    output logic [1:0]            Debug_state
);

    // Handshake: an input beat transfers on a rising edge where Input_valid[i] and
    // Input_ready[i] are both high; a source holds valid/data/last stable until then.
    // The output side has no backpressure: every Output_valid cycle is one consumed beat.

    localparam int GAP_W = (INTERFRAME_GAP > 1) ? $clog2(INTERFRAME_GAP) : 1;

    if (NUM_INPUTS < 2) begin : g_bad_num_inputs
        $error("gmii_frame_arb: NUM_INPUTS must be at least 2");
    end
    if (INTERFRAME_GAP < 1) begin : g_bad_gap
        $error("gmii_frame_arb: INTERFRAME_GAP must be at least 1");
    end
    if (ARB_MODE != 0 && ARB_MODE != 1) begin : g_bad_mode
        $error("gmii_frame_arb: ARB_MODE must be 0 or 1");
    end
    if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > 65535) begin : g_bad_min_len
        $error("gmii_frame_arb: MIN_FRAME_LEN must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
`ifdef GMII_FRAME_ARB_PAD_EN
        ,
        S_PAD    = 2'd3
`endif
    } state_t;

    state_t           state;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] rr_ptr;
    logic [GAP_W-1:0] gap_cnt;

    logic [SRC_W-1:0]      pick;
    logic                  any_valid;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  gap_done;

    assign Debug_state = state;

    // Winner for the next frame; the round-robin search starts one past the last grant.
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                if (Input_valid[i]) pick = SRC_W'(i);
            end
        end else begin
            for (int k = NUM_INPUTS; k >= 1; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
                if (Input_valid[SRC_W'(idx)]) pick = SRC_W'(idx);
            end
        end
    end

    assign any_valid = |Input_valid;
    assign sel_valid = Input_valid[grant];
    assign sel_last  = Input_last[grant];
    assign sel_data  = Input_data[grant];
    assign accept    = (state == S_ACTIVE) && sel_valid && Input_ready[grant];
    assign gap_done  = (gap_cnt == GAP_W'(INTERFRAME_GAP - 1));

`ifdef GMII_FRAME_ARB_PAD_EN
    logic [15:0] beat_cnt;
    logic [15:0] beat_next;
    logic [16:0] beats_incl;
    logic        short_frame;

    assign beat_next   = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
    // Beats sent once the beat leaving this cycle is counted.
    assign beats_incl  = {1'b0, beat_cnt} + 17'd1;
    assign short_frame = (beats_incl < 17'(MIN_FRAME_LEN));
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= S_IDLE;
            grant        <= '0;
            rr_ptr       <= SRC_W'(NUM_INPUTS - 1);
            gap_cnt      <= '0;
            Input_ready  <= '0;
            Output_valid <= 1'b0;
            Output_last  <= 1'b0;
            Output_data  <= '0;
            Output_src   <= '0;
`ifdef GMII_FRAME_ARB_PAD_EN
            beat_cnt     <= '0;
`endif
        end else begin
            Output_valid <= 1'b0;
            Output_last  <= 1'b0;
            Output_data  <= '0;
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant       <= pick;
                        rr_ptr      <= pick;
                        Input_ready <= {{(NUM_INPUTS-1){1'b0}}, 1'b1} << pick;
                        state       <= S_ACTIVE;
`ifdef GMII_FRAME_ARB_PAD_EN
                        beat_cnt    <= '0;
`endif
                    end
                end
                S_ACTIVE: begin
                    if (accept) begin
                        Output_valid <= 1'b1;
                        Output_data  <= sel_data;
                        Output_src   <= grant;
`ifdef GMII_FRAME_ARB_PAD_EN
                        beat_cnt     <= beat_next;
`endif
                        if (sel_last) begin
                            Input_ready <= '0;
                            gap_cnt     <= '0;
`ifdef GMII_FRAME_ARB_PAD_EN
                            // A short frame keeps its end marker for the final pad beat.
                            if (short_frame) begin
                                state <= S_PAD;
                            end else begin
                                state       <= S_GAP;
                                Output_last <= 1'b1;
                            end
`else
                            state       <= S_GAP;
                            Output_last <= 1'b1;
`endif
                        end
                    end
                end
`ifdef GMII_FRAME_ARB_PAD_EN
                S_PAD: begin
                    Output_valid <= 1'b1;
                    Output_src   <= grant;
                    beat_cnt     <= beat_next;
                    if (!short_frame) begin
                        Output_last <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end
                end
`endif
                S_GAP: begin
                    if (gap_done) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    Input_ready <= '0;
                end
            endcase
        end
    end

endmodule
